// File: rtl/rs_pkg.sv
// Shared GF(2^8) arithmetic, generator coefficients and FSM state type for the
// RS(255-k) encoder with six parity symbols.
package rs_pkg;

    localparam int          NPAR    = 6;
    localparam logic [8:0]  GF_POLY = 9'h11D;

    typedef enum logic [1:0] {IDLE, MSG, PAR} state_t;

    function automatic logic [7:0] gf_xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (GF_POLY[7:0] & {8{a[7]}});
    endfunction

    // Shift-and-add multiply; with a constant operand this folds to an XOR network.
    function automatic logic [7:0] gf_mul_const(input logic [7:0] a, input logic [7:0] c);
        logic [7:0] acc;
        logic [7:0] p;
        logic [7:0] cc;
        acc = 8'h00;
        p   = a;
        cc  = c;
        repeat (8) begin
            if (cc[0]) acc = acc ^ p;
            p  = gf_xtime(p);
            cc = cc >> 1;
        end
        return acc;
    endfunction

    // Coefficient idx of g(x) = prod_{i=0..5} (x + alpha^i), expanded at elaboration.
    function automatic logic [7:0] gen_coef(input logic [2:0] idx);
        logic [NPAR:0][7:0] g;
        logic [7:0]         root;
        logic [2:0]         j;
        g    = '0;
        g[0] = 8'h01;
        root = 8'h01;
        repeat (NPAR) begin
            j = 3'd6;
            repeat (NPAR) begin
                g[j] = g[j - 3'd1] ^ gf_mul_const(g[j], root);
                j    = j - 3'd1;
            end
            g[0] = gf_mul_const(g[0], root);
            root = gf_xtime(root);
        end
        return g[idx];
    endfunction

    localparam logic [7:0] G0 = gen_coef(3'd0);
    localparam logic [7:0] G1 = gen_coef(3'd1);
    localparam logic [7:0] G2 = gen_coef(3'd2);
    localparam logic [7:0] G3 = gen_coef(3'd3);
    localparam logic [7:0] G4 = gen_coef(3'd4);
    localparam logic [7:0] G5 = gen_coef(3'd5);

    localparam logic [NPAR-1:0][7:0] GEN = {G5, G4, G3, G2, G1, G0};

endpackage

// File: rtl/rsenc_lfsr.sv
// Six-stage parity register: feeds message symbols through the generator
// division, shifts parity out highest degree first, or clears.
module rsenc_lfsr
    import rs_pkg::*;
(
    input  logic       clk,
    input  logic       clr,
    input  logic       feed,
    input  logic       shift,
    input  logic       clear,
    input  logic [7:0] x,
    output logic [7:0] msb
);

    logic [NPAR-1:0][7:0] r;
    logic [NPAR-1:0][7:0] nxt_feed;
    logic [7:0]           fb;

    assign fb  = x ^ r[NPAR-1];
    assign msb = r[NPAR-1];

    for (genvar i = 0; i < NPAR; i++) begin : g_stage
        if (i == 0) begin : g_first
            assign nxt_feed[i] = gf_mul_const(fb, GEN[i]);
        end else begin : g_rest
            assign nxt_feed[i] = r[i-1] ^ gf_mul_const(fb, GEN[i]);
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr)        r <= '0;
        else if (clear) r <= '0;
        else if (feed)  r <= nxt_feed;
        else if (shift) r <= {r[NPAR-2:0], 8'h00};
    end

endmodule

// File: rtl/rsenc.sv
// Systematic RS encoder, 6 parity symbols: message passes through, parity follows.
// Optional RSENC_SELFCHECK_EN adds a syndrome check on the output stream.
module rsenc
    import rs_pkg::*;
#(
    parameter int NPAR = 6,
    parameter int KMAX = 249
) (
    input  logic       clk,
    input  logic       clr,
    input  logic [7:0] k,
    input  logic       enable,
    input  logic [7:0] x,
    output logic       ready,
    output logic [7:0] y,
    output logic       valid,
    output logic       par,
    output logic       last
`ifdef RSENC_SELFCHECK_EN
    ,
    output logic       check_fail
`endif
);

    if (NPAR != 6) begin : g_bad_npar
        $error("rsenc supports NPAR == 6 only");
    end

    localparam logic [7:0] KMAX8 = 8'(KMAX);
    localparam logic [2:0] PLAST = 3'(NPAR - 1);

    state_t     state;
    logic [7:0] cnt;
    logic [7:0] klat;
    logic [2:0] pcnt;
    logic [7:0] r_msb;
    logic       acc;

    assign ready = (state == MSG) |
                   ((state == IDLE) & (k != 8'd0) & (k <= KMAX8));
    assign acc   = enable & ready;

    rsenc_lfsr u_lfsr (
        .clk   (clk),
        .clr   (clr),
        .feed  (acc),
        .shift (state == PAR),
        .clear ((state == IDLE) & ~acc),
        .x     (x),
        .msb   (r_msb)
    );

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state <= IDLE;
            cnt   <= 8'd0;
            klat  <= 8'd0;
            pcnt  <= 3'd0;
            y     <= 8'd0;
            valid <= 1'b0;
            par   <= 1'b0;
            last  <= 1'b0;
        end else begin
            valid <= 1'b0;
            par   <= 1'b0;
            last  <= 1'b0;
            case (state)
                IDLE: if (acc) begin
                    klat  <= k;
                    cnt   <= 8'd1;
                    pcnt  <= 3'd0;
                    y     <= x;
                    valid <= 1'b1;
                    state <= (k == 8'd1) ? PAR : MSG;
                end
                MSG: if (acc) begin
                    cnt   <= cnt + 8'd1;
                    y     <= x;
                    valid <= 1'b1;
                    if (cnt + 8'd1 == klat) state <= PAR;
                end
                PAR: begin
                    y     <= r_msb;
                    valid <= 1'b1;
                    par   <= 1'b1;
                    last  <= (pcnt == PLAST);
                    pcnt  <= pcnt + 3'd1;
                    if (pcnt == PLAST) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef RSENC_SELFCHECK_EN
    // Horner evaluation of the emitted codeword at alpha^0..alpha^5.
    logic [NPAR-1:0][7:0] syn;
    logic [NPAR-1:0][7:0] syn_nxt;

    for (genvar j = 0; j < NPAR; j++) begin : g_syn
        assign syn_nxt[j] = gf_mul_const(syn[j], 8'(1 << j)) ^ y;
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            syn        <= '0;
            check_fail <= 1'b0;
        end else begin
            check_fail <= 1'b0;
            if (valid) begin
                if (last) begin
                    check_fail <= |syn_nxt;
                    syn        <= '0;
                end else begin
                    syn <= syn_nxt;
                end
            end
        end
    end
`endif

endmodule
